// File: rtl/dram_port_arbiter.sv
// Shares the single data-RAM port between the CPU (port 0) and the debug/DMA loader (port 1).
// Each access is a REQ/GNT/ACK handshake; the winner is chosen by round-robin or fixed CPU priority.
module dram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int READ_LAT = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [DW-1:0] WDATA0,
  output logic          GNT0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT1,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MDATA,
  output logic          MW,
  input  logic [DW-1:0] MQ,
  output logic          BUSY
);
  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          win_q, we_q, ptr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [CW-1:0] cnt_q;
  logic          req_any, pick, pick_we, last;

  assign req_any = REQ0 | REQ1;
  // On a tie, fixed priority favours the CPU; otherwise the round-robin pointer decides.
  assign pick    = (REQ0 & REQ1) ? ((CPU_PRIO != 0) ? 1'b0 : ptr_q) : REQ1;
  assign pick_we = pick ? WE1 : WE0;
  assign last    = (cnt_q == CW'(1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  if (last)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched at the win so a requester misbehaving mid-access cannot corrupt it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE && req_any) begin
      win_q   <= pick;
      we_q    <= pick_we;
      addr_q  <= pick ? ADDR1 : ADDR0;
      wdata_q <= pick ? WDATA1 : WDATA0;
      cnt_q   <= pick_we ? CW'(1) : CW'(READ_LAT);
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q - CW'(1);
      if (last) begin
        if (!we_q) rdata_q <= MQ;
        ptr_q <= ~win_q;
      end
    end
  end

  always_comb begin
    GNT0 = (state_q == ACCESS) & ~win_q;
    GNT1 = (state_q == ACCESS) &  win_q;
    ACK0 = (state_q == DONE)   & ~win_q;
    ACK1 = (state_q == DONE)   &  win_q;
    MW   = (state_q == ACCESS) &  we_q;
    BUSY = (state_q != IDLE);
  end

  assign MADDR = addr_q;
  assign MDATA = wdata_q;
  assign RDATA = rdata_q;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: two instances (RR/latency 1 and CPU-priority/latency 3) driven in
// parallel, directed scenarios plus random traffic against a transaction-schedule model.
module tb_dram_port_arbiter;
  localparam int LAT_A = 1, PRIO_A = 0;
  localparam int LAT_B = 3, PRIO_B = 1;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic       REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
  logic [7:0] ADDR0 = '0, WDATA0 = '0, ADDR1 = '0, WDATA1 = '0;
  logic [1:0] gnt0, gnt1, ack0, ack1, mw, busy;
  logic [7:0] maddr [2], mdata [2], rdata [2], mq [2];
  logic [5:0] act_ctl [2], exp_ctl [2];

  int n_cmp = 0, n_bad = 0;

  dram_port_arbiter #(.AW(8), .DW(8), .READ_LAT(LAT_A), .CPU_PRIO(PRIO_A)) u_a (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .GNT0(gnt0[0]), .ACK0(ack0[0]),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .GNT1(gnt1[0]), .ACK1(ack1[0]),
    .RDATA(rdata[0]), .MADDR(maddr[0]), .MDATA(mdata[0]), .MW(mw[0]), .MQ(mq[0]), .BUSY(busy[0]));

  dram_port_arbiter #(.AW(8), .DW(8), .READ_LAT(LAT_B), .CPU_PRIO(PRIO_B)) u_b (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .GNT0(gnt0[1]), .ACK0(ack0[1]),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .GNT1(gnt1[1]), .ACK1(ack1[1]),
    .RDATA(rdata[1]), .MADDR(maddr[1]), .MDATA(mdata[1]), .MW(mw[1]), .MQ(mq[1]), .BUSY(busy[1]));

  assign act_ctl[0] = {gnt0[0], gnt1[0], ack0[0], ack1[0], mw[0], busy[0]};
  assign act_ctl[1] = {gnt0[1], gnt1[1], ack0[1], ack1[1], mw[1], busy[1]};

  // RAM models: contents reload to addr^0xB5 while in reset; instance B's Q lags MADDR by 2 edges.
  logic [7:0] mem [2][256];
  logic [7:0] adly1, adly2;
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RESET) for (int a = 0; a < 256; a++) mem[k][a] <= 8'(a) ^ 8'hB5;
      else if (mw[k]) mem[k][maddr[k]] <= mdata[k];
    end
    adly1 <= maddr[1];
    adly2 <= adly1;
  end
  assign mq[0] = mem[0][maddr[0]];
  assign mq[1] = mem[1][adly2];

  // Reference model: each accepted request is scheduled as grant/ack/free cycle numbers.
  int         cyc = 0;
  int         free_at [2], g_lo [2], g_hi [2], ack_at [2];
  logic       win [2], we_l [2], ptr [2];
  logic [7:0] a_l [2], d_l [2], e_rdata [2];
  logic [7:0] refmem [2][256];

  function automatic int lat_of(int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction
  function automatic logic pick(int k);
    if (REQ0 && REQ1) return (((k == 0) ? PRIO_A : PRIO_B) != 0) ? 1'b0 : ptr[k];
    return REQ1;
  endfunction
  function automatic int acc_len(int k);
    return (pick(k) ? WE1 : WE0) ? 1 : lat_of(k);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RESET) begin
    for (int k = 0; k < 2; k++) begin
      if (!RESET) begin
        free_at[k] <= 0; g_lo[k] <= -5; g_hi[k] <= -6; ack_at[k] <= -1;
        win[k] <= 1'b0; we_l[k] <= 1'b0; ptr[k] <= 1'b0;
        a_l[k] <= '0; d_l[k] <= '0; e_rdata[k] <= '0;
        for (int a = 0; a < 256; a++) refmem[k][a] <= 8'(a) ^ 8'hB5;
      end else begin
        if (cyc == g_lo[k] && we_l[k]) refmem[k][a_l[k]] <= d_l[k];
        if (cyc == g_hi[k] && !we_l[k]) e_rdata[k] <= refmem[k][a_l[k]];
        if (cyc >= free_at[k] && (REQ0 || REQ1)) begin
          win[k]     <= pick(k);
          we_l[k]    <= pick(k) ? WE1 : WE0;
          a_l[k]     <= pick(k) ? ADDR1 : ADDR0;
          d_l[k]     <= pick(k) ? WDATA1 : WDATA0;
          g_lo[k]    <= cyc + 1;
          g_hi[k]    <= cyc + acc_len(k);
          ack_at[k]  <= cyc + acc_len(k) + 1;
          free_at[k] <= cyc + acc_len(k) + 2;
          ptr[k]     <= ~pick(k);
        end
      end
    end
  end

  always_comb begin
    exp_ctl = '{default: '0};
    for (int k = 0; k < 2; k++)
      exp_ctl[k] = {(cyc >= g_lo[k] && cyc <= g_hi[k] && !win[k]),
                    (cyc >= g_lo[k] && cyc <= g_hi[k] &&  win[k]),
                    (cyc == ack_at[k] && !win[k]),
                    (cyc == ack_at[k] &&  win[k]),
                    (cyc == g_lo[k] && we_l[k]),
                    (cyc >= g_lo[k] && cyc <= ack_at[k])};
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    tick(); tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b0) begin n_bad++; $display("FAIL reset_ctl k=%0d got %b want 000000", k, act_ctl[k]); end
      n_cmp++; if (maddr[k] !== 8'h00) begin n_bad++; $display("FAIL reset_maddr k=%0d got %h want 00", k, maddr[k]); end
      n_cmp++; if (mdata[k] !== 8'h00) begin n_bad++; $display("FAIL reset_mdata k=%0d got %h want 00", k, mdata[k]); end
      n_cmp++; if (rdata[k] !== 8'h00) begin n_bad++; $display("FAIL reset_rdata k=%0d got %h want 00", k, rdata[k]); end
    end
  endtask

  task automatic test_write();
    logic [5:0] tw [4];
    tw = '{6'b000000, 6'b100011, 6'b001001, 6'b000000};
    do_reset();
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 8'h10; WDATA0 = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (act_ctl[k] !== tw[c]) begin n_bad++; $display("FAIL write_ctl k=%0d c=%0d got %b want %b", k, c, act_ctl[k], tw[c]); end
        if (c == 1) begin
          n_cmp++;
          if (maddr[k] !== 8'h10 || mdata[k] !== 8'hA5) begin
            n_bad++; $display("FAIL write_bus k=%0d got %h/%h want 10/a5", k, maddr[k], mdata[k]);
          end
        end
      end
      tick();
      if (c == 2) REQ0 = 1'b0;
    end
  endtask

  task automatic test_read();
    logic [5:0] ra [3];
    logic [5:0] rb [5];
    ra = '{6'b000000, 6'b010001, 6'b000101};
    rb = '{6'b000000, 6'b010001, 6'b010001, 6'b010001, 6'b000101};
    do_reset();
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 8'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c <= 2) begin
        n_cmp++; if (act_ctl[0] !== ra[c]) begin n_bad++; $display("FAIL read_ctl_a c=%0d got %b want %b", c, act_ctl[0], ra[c]); end
      end
      if (c <= 4) begin
        n_cmp++; if (act_ctl[1] !== rb[c]) begin n_bad++; $display("FAIL read_ctl_b c=%0d got %b want %b", c, act_ctl[1], rb[c]); end
      end
      if (c == 2) begin
        n_cmp++; if (rdata[0] !== 8'hA5) begin n_bad++; $display("FAIL read_data_a got %h want a5", rdata[0]); end
      end
      if (c == 3) begin
        n_cmp++; if (rdata[1] !== 8'h00) begin n_bad++; $display("FAIL read_early_b got %h want 00", rdata[1]); end
      end
      if (c == 4) begin
        n_cmp++; if (rdata[1] !== 8'hA5) begin n_bad++; $display("FAIL read_data_b got %h want a5", rdata[1]); end
      end
      tick();
      if (c == 4) REQ1 = 1'b0;
    end
  endtask

  task automatic test_rr_contention();
    logic [3:0] e;
    int m, s;
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0; ADDR0 = 8'h01; ADDR1 = 8'h02;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      m = c % 3;
      s = (c / 3) % 2;
      e = {(m == 1 && s == 0), (m == 1 && s == 1), (m == 2 && s == 0), (m == 2 && s == 1)};
      n_cmp++; if (act_ctl[0][5:2] !== e) begin n_bad++; $display("FAIL rr_gnt_ack c=%0d got %b want %b", c, act_ctl[0][5:2], e); end
      tick();
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_prio();
    logic [3:0] e;
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0; ADDR0 = 8'h03; ADDR1 = 8'h04;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      e = {((c >= 1 && c <= 3) || (c >= 6 && c <= 8)), (c >= 11 && c <= 13), (c == 4 || c == 9), (c == 14)};
      n_cmp++; if (act_ctl[1][5:2] !== e) begin n_bad++; $display("FAIL prio_gnt_ack c=%0d got %b want %b", c, act_ctl[1][5:2], e); end
      tick();
      if (c == 9)  REQ0 = 1'b0;
      if (c == 14) REQ1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'h05;
    tick(); tick();
    REQ0 = 1'b0;
    repeat (5) tick();
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 8'h40; WDATA0 = 8'hEE;
    tick();
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b100011) begin n_bad++; $display("FAIL rmid_pre k=%0d got %b want 100011", k, act_ctl[k]); end
    end
    #2;
    RESET = 1'b0; REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 8'h41;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b0) begin n_bad++; $display("FAIL rmid_async k=%0d got %b want 000000", k, act_ctl[k]); end
    end
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b0) begin n_bad++; $display("FAIL rmid_noack k=%0d got %b want 000000", k, act_ctl[k]); end
    end
    tick();
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b100011) begin n_bad++; $display("FAIL rmid_regrant k=%0d got %b want 100011", k, act_ctl[k]); end
    end
    tick();
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (act_ctl[k] !== 6'b001001) begin n_bad++; $display("FAIL rmid_ack k=%0d got %b want 001001", k, act_ctl[k]); end
    end
    tick();
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 8'h22;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c == 2) begin
        n_cmp++; if (act_ctl[0] !== 6'b001001) begin n_bad++; $display("FAIL drop_ack_a got %b want 001001", act_ctl[0]); end
        n_cmp++; if (rdata[0] !== 8'h97) begin n_bad++; $display("FAIL drop_data_a got %h want 97", rdata[0]); end
      end
      if (c == 3) begin
        n_cmp++; if (maddr[1] !== 8'h22) begin n_bad++; $display("FAIL drop_addr_b got %h want 22", maddr[1]); end
      end
      if (c == 4) begin
        n_cmp++; if (act_ctl[1] !== 6'b001001) begin n_bad++; $display("FAIL drop_ack_b got %b want 001001", act_ctl[1]); end
        n_cmp++; if (rdata[1] !== 8'h97) begin n_bad++; $display("FAIL drop_data_b got %h want 97", rdata[1]); end
      end
      tick();
      if (c == 0) begin REQ0 = 1'b0; ADDR0 = 8'h33; end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RESET  = ($urandom_range(0, 99) != 0);
      REQ0   = ($urandom_range(0, 2) != 0);
      REQ1   = ($urandom_range(0, 2) != 0);
      WE0    = 1'($urandom_range(0, 1));
      WE1    = 1'($urandom_range(0, 1));
      ADDR0  = 8'($urandom_range(0, 7));
      ADDR1  = 8'($urandom_range(0, 7));
      WDATA0 = 8'($urandom);
      WDATA1 = 8'($urandom);
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (act_ctl[k] !== exp_ctl[k]) begin n_bad++; $display("FAIL rand_ctl k=%0d i=%0d got %b want %b", k, i, act_ctl[k], exp_ctl[k]); end
        n_cmp++; if (maddr[k] !== a_l[k]) begin n_bad++; $display("FAIL rand_maddr k=%0d i=%0d got %h want %h", k, i, maddr[k], a_l[k]); end
        n_cmp++; if (mdata[k] !== d_l[k]) begin n_bad++; $display("FAIL rand_mdata k=%0d i=%0d got %h want %h", k, i, mdata[k], d_l[k]); end
        n_cmp++; if (rdata[k] !== e_rdata[k]) begin n_bad++; $display("FAIL rand_rdata k=%0d i=%0d got %h want %h", k, i, rdata[k], e_rdata[k]); end
      end
      tick();
    end
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rr_contention();
    test_prio();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Shares the single data-RAM port (8-bit address, 8-bit write data, MW write strobe, 8-bit read data) between two requesters: port 0 is the CPU load/store path and port 1 is the debug/DMA loader. Each access is a registered, single-transaction REQ/GNT/ACK handshake. The block sequences the RAM strobes for each access, including a configurable RAM read latency, and selects the winner by round-robin or by fixed CPU priority. It sits between the cpu and dram instances in the top-level microprocessor and drives the dram ADDR/DATA/MW inputs.

Parameters:
AW, 8, address width
DW, 8, data width
READ_LAT, 1, RAM cycles from address valid to Q valid (legal range 1..7)
CPU_PRIO, 0, 1 = port 0 always wins a tie; 0 = round-robin

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
REQ0  in  1  port 0 request; held high until ACK0
WE0  in  1  port 0 write (1) or read (0); stable while REQ0 is high
ADDR0  in  AW  port 0 address
WDATA0  in  DW  port 0 write data
GNT0  out  1  port 0 owns the RAM
ACK0  out  1  one-cycle completion pulse for port 0
REQ1, WE1, ADDR1, WDATA1, GNT1, ACK1  same as port 0, for port 1
RDATA  out  DW  read data; valid in the ACK cycle
MADDR  out  AW  to dram ADDR
MDATA  out  DW  to dram DATA
MW  out  1  to dram MW
MQ  in  DW  from dram Q
BUSY  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - GNT0/1, ACK0/1, MW and BUSY are 0.
  - MADDR, MDATA and RDATA are 0.
  - Latency counter is 0.
  - Round-robin pointer selects port 0 next.
  - Reset asserted mid-access aborts the access: no ACK is issued and MW drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - REQ inputs are sampled at each rising edge.
  - If no request is active, stay in IDLE.
  - If exactly one request is active, that port wins.
  - If both are active and CPU_PRIO=1, port 0 wins. If CPU_PRIO=0, the pointer's port wins.
  - On a win: latch the winner's ADDR, WDATA and WE; set its GNT; load the counter (READ_LAT for a read, 1 for a write); go to ACCESS.
- ACCESS:
  - MADDR and MDATA come from the latched registers.
  - MW = latched WE. MW is therefore high for exactly one cycle per write and never high at any other time.
  - The counter decrements each cycle.
  - When the counter reaches 1: capture MQ into RDATA (reads only; RDATA is unchanged on writes), drop GNT, pulse the winner's ACK, flip the pointer to the other port, and go to DONE.
- DONE:
  - Lasts one cycle and ignores REQ inputs. ACK is high during this cycle.
  - Next state is IDLE.
  - A REQ still high in the IDLE cycle after ACK counts as a new transaction.
- Timing (REQ first seen high in IDLE cycle t):
  - GNT high in cycles t+1 .. t+LAT, where LAT = READ_LAT for a read and 1 for a write.
  - ACK high in cycle t+1+LAT.
  - Back-to-back accesses repeat every LAT+2 cycles.
- MADDR and MDATA hold their last values in IDLE/DONE.
- Only one GNT and one ACK may be high at any time.
- Protocol violations:
  - If REQ drops or ADDR changes during ACCESS, the access still completes on the latched values and ACK is still issued.
  - A request on the non-granted port waits; it is never dropped.
- Round-robin mode guarantees each continuously requesting port is served at least every second grant.

Test Plan:
- Write, READ_LAT=1: REQ0=1, WE0=1, ADDR0=0x10, WDATA0=0xA5 at cycle 0 -> GNT0 and MW=1 in cycle 1, MADDR=0x10, MDATA=0xA5; ACK0 in cycle 2; MW=0 in all other cycles.
- Read, READ_LAT=3: REQ1=1, ADDR1=0x10, RAM holds 0xA5 -> GNT1 high in cycles 1-3; ACK1 and RDATA=0xA5 in cycle 4; MW never high.
- Contention, CPU_PRIO=0: REQ0 and REQ1 high continuously with reads -> grants alternate 0,1,0,1; ACKs 3 cycles apart at READ_LAT=1; GNT0 and GNT1 never overlap.
- Contention, CPU_PRIO=1: both requesting; REQ0 dropped after its 2nd ACK -> port 0 served twice, then port 1 granted in the next IDLE cycle.
- Reset mid-access: RESET=0 during write ACCESS -> MW, GNT and BUSY go to 0 asynchronously; no ACK; after release, REQ1 pending with REQ0 also pending -> port 0 wins (pointer reset).
- Request dropped during ACCESS: REQ0 falls in cycle 1 of a READ_LAT=2 read -> ACK0 still issued in cycle 3 with the RDATA of the latched address.
